// File: rtl/fetch_unit.sv
// fetch_unit: MIPS R2000 instruction fetch stage, producer side of the IF/ID register.
// Latency: zero-wait memory puts a word in IF/ID one edge after its request; N wait states give 1/(N+1).
// Backpressure: hold_pc blocks new requests, hold_if freezes IF/ID; a word landing under hold_if parks in a 1-entry skid.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   hold_pc, hold_if         decode stall requests
//   br, pc_branch            taken branch from ID and its target (low two bits ignored)
//   exception                undefined-opcode exception from ID
//   imem_req/addr/ack/rdata  instruction memory handshake; ack may come in the request cycle
//   inst_id, pc_id, valid_id IF/ID register (instruction, PC+4, slot valid)
//   flush_id                 one-cycle pulse after a redirect flushes IF/ID
//   exc_pc                   address of the faulting instruction
//
// Optional feature: define FETCH_EXC_EN to make `exception` redirect to EXC_VECTOR and
// capture exc_pc. Without it, `exception` is ignored and exc_pc stays 0.

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_pc,
  input  logic        hold_if,
  input  logic        br,
  input  logic [31:0] pc_branch,
  input  logic        exception,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_id,
  output logic [31:0] pc_id,
  output logic        valid_id,
  output logic        flush_id,
  output logic [31:0] exc_pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_nxt;

  logic [31:0] pc, pc_nxt;
  logic [31:0] addr_q, addr_q_nxt;
  logic        outstanding, outstanding_nxt;
  logic [31:0] skid_inst, skid_inst_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
  logic        skid_v, skid_v_nxt;
  logic [31:0] inst_id_nxt, pc_id_nxt;
  logic        valid_id_nxt, flush_id_nxt;
  logic [31:0] exc_pc_nxt;

  logic        exc_take;
  logic [31:0] exc_pc_calc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req_raw;
  logic        acked;
  logic        stuck;
  logic [31:0] addr_inc;

`ifdef FETCH_EXC_EN
  assign exc_take    = exception;
  assign exc_pc_calc = pc_id - 32'd4;
`else
  assign exc_take    = 1'b0;
  assign exc_pc_calc = 32'd0;
  logic unused_exception;
  assign unused_exception = exception;
`endif

  // Targets are word aligned; the byte-offset bits of the branch target carry no meaning here.
  logic unused_pcb_lsb;
  assign unused_pcb_lsb = ^pc_branch[1:0];

  // Exception takes priority over a branch resolved in the same cycle.
  assign redirect    = br | exc_take;
  assign redirect_pc = exc_take ? EXC_VECTOR : {pc_branch[31:2], 2'b00};

  // A request already on the bus must stay up until acked, whatever the stalls say.
  // DRAIN always has its request outstanding; naming it keeps that explicit.
  assign req_raw   = ((state == FETCH) && !hold_pc && !skid_v) || outstanding || (state == DRAIN);
  assign imem_req  = rst_n & req_raw;
  assign imem_addr = outstanding ? addr_q : pc;
  assign acked     = imem_req & imem_ack;
  assign stuck     = imem_req & ~imem_ack;
  assign addr_inc  = imem_addr + 32'd4;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    addr_q_nxt      = addr_q;
    outstanding_nxt = outstanding;
    skid_inst_nxt   = skid_inst;
    skid_pc_nxt     = skid_pc;
    skid_v_nxt      = skid_v;
    inst_id_nxt     = inst_id;
    pc_id_nxt       = pc_id;
    valid_id_nxt    = valid_id;
    flush_id_nxt    = 1'b0;
    exc_pc_nxt      = exc_pc;

    // Latch the address of a request that was not acked so it can be replayed unchanged.
    if (stuck) begin
      outstanding_nxt = 1'b1;
      addr_q_nxt      = imem_addr;
    end else if (acked) begin
      outstanding_nxt = 1'b0;
    end

    if (redirect && (state != DRAIN)) begin
      // Redirect beats both stalls: kill IF/ID and the skid, restart at the target.
      // Any same-cycle ack data is simply not captured.
      pc_nxt       = redirect_pc;
      inst_id_nxt  = 32'd0;
      pc_id_nxt    = 32'd0;
      valid_id_nxt = 1'b0;
      skid_v_nxt   = 1'b0;
      flush_id_nxt = 1'b1;
      if (exc_take) begin
        exc_pc_nxt = exc_pc_calc;
      end
      state_nxt    = stuck ? DRAIN : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (acked) begin
            pc_nxt = addr_inc;
            if (!hold_if) begin
              inst_id_nxt  = imem_rdata;
              pc_id_nxt    = addr_inc;
              valid_id_nxt = 1'b1;
            end else begin
              skid_inst_nxt = imem_rdata;
              skid_pc_nxt   = addr_inc;
              skid_v_nxt    = 1'b1;
              state_nxt     = STALL;
            end
          end else if (!hold_if) begin
            // Decode took the previous word this edge and nothing new arrived.
            valid_id_nxt = 1'b0;
          end
        end

        STALL: begin
          if (!hold_if) begin
            inst_id_nxt  = skid_inst;
            pc_id_nxt    = skid_pc;
            valid_id_nxt = 1'b1;
            skid_v_nxt   = 1'b0;
            state_nxt    = FETCH;
          end
        end

        DRAIN: begin
          // The wrong-path request must finish on the bus; its data is dropped.
          // IF/ID was already flushed when DRAIN was entered.
          if (redirect) begin
            pc_nxt = redirect_pc;
          end
          if (acked) begin
            state_nxt = FETCH;
          end
        end

        default: begin
          state_nxt = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      addr_q      <= 32'd0;
      outstanding <= 1'b0;
      skid_inst   <= 32'd0;
      skid_pc     <= 32'd0;
      skid_v      <= 1'b0;
      inst_id     <= 32'd0;
      pc_id       <= 32'd0;
      valid_id    <= 1'b0;
      flush_id    <= 1'b0;
      exc_pc      <= 32'd0;
    end else begin
      pc          <= pc_nxt;
      addr_q      <= addr_q_nxt;
      outstanding <= outstanding_nxt;
      skid_inst   <= skid_inst_nxt;
      skid_pc     <= skid_pc_nxt;
      skid_v      <= skid_v_nxt;
      inst_id     <= inst_id_nxt;
      pc_id       <= pc_id_nxt;
      valid_id    <= valid_id_nxt;
      flush_id    <= flush_id_nxt;
      exc_pc      <= exc_pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold_pc = 1'b0;
  logic        hold_if = 1'b0;
  logic        br = 1'b0;
  logic [31:0] pc_branch = 32'd0;
  logic        exception = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic        valid_id;
  logic        flush_id;
  logic [31:0] exc_pc;

  int total = 0;
  int bad = 0;

`ifdef FETCH_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC = 32'h0000_0080;

  fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold_pc   (hold_pc),
    .hold_if   (hold_if),
    .br        (br),
    .pc_branch (pc_branch),
    .exception (exception),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .inst_id   (inst_id),
    .pc_id     (pc_id),
    .valid_id  (valid_id),
    .flush_id  (flush_id),
    .exc_pc    (exc_pc)
  );

  always #5 clk = ~clk;

  // Memory model state
  int          min_w = 0;
  int          max_w = 0;
  int          wait_tgt = 0;
  int          wcnt = 0;
  logic        busy = 1'b0;
  logic [31:0] busy_addr = 32'd0;
  logic        force_ack = 1'b0;

  // Program-order reference: address of the next instruction decode must receive.
  logic [31:0] exp_addr = RST_PC;
  logic        draining = 1'b0;
  logic        flush_due = 1'b0;
  logic        redir_prev = 1'b0;
  int          delivered = 0;

  // Per-cycle observations for directed checks
  logic        o_req, o_valid, o_flush;
  logic [31:0] o_addr, o_inst, o_pcid, o_exc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, want);
    end
  endtask

  // One clock cycle. Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic cycle();
    logic        redir;
    logic        was_drain;
    logic [31:0] tgt;
    #2;
    if (!rst_n) begin
      imem_ack   = force_ack;
      imem_rdata = $urandom;
      busy       = 1'b0;
      draining   = 1'b0;
      flush_due  = 1'b0;
      redir_prev = 1'b0;
      exp_addr   = RST_PC;
      #1;
    end else begin
      if (busy) begin
        check1("bus_req_held", imem_req, 1'b1);
        check32("bus_addr_held", imem_addr, busy_addr);
      end
      if (imem_req) begin
        if (!busy) begin
          wait_tgt  = $urandom_range(max_w, min_w);
          wcnt      = 0;
          busy_addr = imem_addr;
        end
        imem_ack   = (wcnt >= wait_tgt);
        imem_rdata = imem_ack ? memf(imem_addr) : $urandom;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
      end
      #1;
      o_req   = imem_req;
      o_addr  = imem_addr;
      o_inst  = inst_id;
      o_pcid  = pc_id;
      o_valid = valid_id;
      o_flush = flush_id;
      o_exc   = exc_pc;

      if (imem_req) check1("addr_align", (imem_addr[1:0] == 2'b00), 1'b1);
      check1("flush_pulse", flush_id, flush_due);
      if (redir_prev) check1("valid_after_redirect", valid_id, 1'b0);

      redir = br | (EXC_EN & exception);
      tgt   = (EXC_EN && exception) ? EXC_VEC : {pc_branch[31:2], 2'b00};
      if (!redir && valid_id && !hold_if) begin
        check32("stream_pc", pc_id, exp_addr + 32'd4);
        check32("stream_inst", inst_id, memf(exp_addr));
        exp_addr = exp_addr + 32'd4;
        delivered++;
      end
      was_drain = draining;
      if (imem_req && imem_ack) draining = 1'b0;
      if (redir && imem_req && !imem_ack) draining = 1'b1;
      flush_due  = redir && !was_drain;
      redir_prev = redir;
      if (redir) exp_addr = tgt;

      if (imem_req && !imem_ack) begin
        busy = 1'b1;
        wcnt++;
      end else begin
        busy = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    br        = 1'b0;
    exception = 1'b0;
    hold_pc   = 1'b0;
    hold_if   = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;

    // Reset values while rst_n is low (hold_pc=0 would otherwise request)
    #2;
    check1("rst_req", imem_req, 1'b0);
    check32("rst_inst", inst_id, 32'd0);
    check32("rst_pcid", pc_id, 32'd0);
    check1("rst_valid", valid_id, 1'b0);
    check1("rst_flush", flush_id, 1'b0);
    check32("rst_excpc", exc_pc, 32'd0);
    @(posedge clk);
    #1;

    // Zero-wait streaming after reset release
    min_w = 0; max_w = 0;
    do_reset();
    cycle();
    check1("zw_c1_req", o_req, 1'b1);
    check32("zw_c1_addr", o_addr, 32'h0);
    check1("zw_c1_valid", o_valid, 1'b0);
    cycle();
    check32("zw_c2_addr", o_addr, 32'h4);
    check1("zw_c2_valid", o_valid, 1'b1);
    check32("zw_c2_pcid", o_pcid, 32'h4);
    check32("zw_c2_inst", o_inst, memf(32'h0));
    cycle();
    check32("zw_c3_addr", o_addr, 32'h8);
    check32("zw_c3_pcid", o_pcid, 32'h8);
    cycle();
    check32("zw_c4_pcid", o_pcid, 32'hC);
    check1("zw_c4_valid", o_valid, 1'b1);

    // Two wait states: address held 3 cycles, one instruction every 3 cycles
    min_w = 2; max_w = 2;
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      cycle();
      check32("w2_addr", o_addr, (i <= 3) ? 32'h0 : ((i <= 6) ? 32'h4 : 32'h8));
      check1("w2_valid", o_valid, (i == 4) || (i == 7));
    end
    check32("w2_c7_pcid", o_pcid, 32'h8);

    // Stall with an ack landing in the first hold cycle (1-wait memory)
    min_w = 1; max_w = 1;
    do_reset();
    cycle(); cycle(); cycle();
    check1("hold_c3_valid", o_valid, 1'b1);
    hold_pc = 1'b1; hold_if = 1'b1;
    cycle();
    check1("hold_c4_req", o_req, 1'b1);
    check32("hold_c4_addr", o_addr, 32'h4);
    check32("hold_c4_inst", o_inst, memf(32'h0));
    cycle();
    check1("hold_c5_req", o_req, 1'b0);
    check32("hold_c5_inst", o_inst, memf(32'h0));
    cycle();
    check32("hold_c6_pcid", o_pcid, 32'h4);
    hold_pc = 1'b0; hold_if = 1'b0;
    cycle();
    check1("hold_rel_norefetch", o_req, 1'b0);
    check32("hold_rel_inst_old", o_inst, memf(32'h0));
    cycle();
    check1("skid_valid", o_valid, 1'b1);
    check32("skid_inst", o_inst, memf(32'h4));
    check32("skid_pcid", o_pcid, 32'h8);
    check32("skid_next_addr", o_addr, 32'h8);

    // Branch while a 2-wait request to 0x10 is in flight
    min_w = 2; max_w = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (o_req && o_addr == 32'h10) found = 1'b1;
    end
    check1("br_reach_0x10", found, 1'b1);
    br = 1'b1; pc_branch = 32'h40;
    cycle();
    br = 1'b0;
    check32("br_inflight_addr", o_addr, 32'h10);
    cycle();
    check1("br_flush", o_flush, 1'b1);
    check1("br_valid0", o_valid, 1'b0);
    check32("br_drain_addr", o_addr, 32'h10);
    cycle();
    check1("br_flush_once", o_flush, 1'b0);
    check1("br_new_req", o_req, 1'b1);
    check32("br_new_addr", o_addr, 32'h40);
    cycle(); cycle(); cycle();
    check1("br_tgt_valid", o_valid, 1'b1);
    check32("br_tgt_pcid", o_pcid, 32'h44);
    check32("br_tgt_inst", o_inst, memf(32'h40));

    // Exception handling
    min_w = 0; max_w = 0;
    do_reset();
`ifdef FETCH_EXC_EN
    repeat (9) cycle();
    exception = 1'b1; br = 1'b1; pc_branch = 32'h100;
    cycle();
    check32("exc_pcid_at", o_pcid, 32'h24);
    exception = 1'b0; br = 1'b0;
    cycle();
    check32("exc_vec_addr", o_addr, 32'h80);
    check1("exc_flush", o_flush, 1'b1);
    check32("exc_pc", o_exc, 32'h20);
    cycle();
    check32("exc_vec_pcid", o_pcid, 32'h84);
    check32("exc_vec_inst", o_inst, memf(32'h80));
`else
    repeat (4) cycle();
    exception = 1'b1;
    cycle();
    exception = 1'b0;
    cycle();
    check1("exc_ignored_flush", o_flush, 1'b0);
    check1("exc_ignored_valid", o_valid, 1'b1);
    check32("exc_ignored_pcid", o_pcid, 32'h14);
    check32("exc_pc_tied", o_exc, 32'h0);
`endif

    // PC wrap at the top of the address space (low target bits ignored)
    br = 1'b1; pc_branch = 32'hFFFF_FFFE;
    cycle();
    br = 1'b0;
    cycle();
    check32("wrap_req_addr", o_addr, 32'hFFFF_FFFC);
    cycle();
    check32("wrap_next_addr", o_addr, 32'h0);
    check32("wrap_pcid", o_pcid, 32'h0);
    check32("wrap_inst", o_inst, memf(32'hFFFF_FFFC));

    // Reset in the middle of a 3-wait request; its late ack must be ignored
    min_w = 3; max_w = 3;
    cycle(); cycle(); cycle();
    rst_n = 1'b0;
    #1;
    check1("midrst_req", imem_req, 1'b0);
    check1("midrst_valid", valid_id, 1'b0);
    check32("midrst_pcid", pc_id, 32'h0);
    check32("midrst_inst", inst_id, 32'h0);
    check1("midrst_flush", flush_id, 1'b0);
    check32("midrst_excpc", exc_pc, 32'h0);
    force_ack = 1'b1;
    cycle();
    force_ack = 1'b0;
    rst_n = 1'b1;
    min_w = 0; max_w = 0;
    cycle();
    check32("postrst_addr", o_addr, RST_PC);
    check1("postrst_valid", o_valid, 1'b0);
    cycle();
    check32("postrst_pcid", o_pcid, RST_PC + 32'd4);

    // Randomized traffic against the program-order model
    min_w = 0; max_w = 3;
    delivered = 0;
    for (int i = 0; i < 1500; i++) begin
      logic ho;
      ho        = ($urandom_range(0, 4) == 0);
      hold_pc   = ho;
      hold_if   = ho ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      br        = ($urandom_range(0, 9) == 0);
      pc_branch = $urandom;
      exception = EXC_EN ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) == 0);
      cycle();
    end
    hold_pc = 1'b0; hold_if = 1'b0; br = 1'b0; exception = 1'b0;
    check1("rand_progress", (delivered >= 100), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
